// File: rtl/sample_uart_tx_if.sv
// Push/status bundle between the sample producer and the UART transmitter.
interface sample_uart_tx_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16
);
    logic                          sample_valid;
    logic [DATA_W-1:0]             sample_data;
    logic                          busy;
    logic                          fifo_full;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output sample_valid,
        output sample_data,
        input  busy,
        input  fifo_full,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output busy,
        output fifo_full,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/sample_uart_tx.sv
// Buffers strobed samples in a FIFO and sends each one over UART 8N1,
// least-significant byte first, with no idle gap while data is queued.
module sample_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned DATA_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    sample_uart_tx_if.slave bus,
    output logic            uart_tx
);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(NumBytes - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [ByteW-1:0]  byte_q, byte_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic              pop, push, baud_done, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign baud_done  = (baud_q == BaudLast);

    // A full FIFO still accepts a push when the FSM frees a slot on the same edge.
    assign push       = bus.sample_valid && ((count_q != CntFull) || pop);
    assign count_d    = count_q + CntW'(push) - CntW'(pop);
    assign overflow_d = overflow_q | (bus.sample_valid & ~push);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.sample_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    // The shift register moves right after every data bit, so the bit on the
    // line is always shift_q[0] and the next byte lands in the low octet.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != ByteLast) begin
                        byte_d  = byte_q + ByteW'(1);
                        state_d = StStart;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        byte_d  = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the current state, so it lags the state by one edge.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx        = tx_q;
    assign bus.busy       = (state_q != StIdle) | (count_q != '0);
    assign bus.fifo_full  = (count_q == CntFull);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sample_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes the line and compares.
module tb_sample_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_tx;

    always #5 clk = ~clk;

    sample_uart_tx_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    sample_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .DATA_W      (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .uart_tx(uart_tx)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         rx_bytes = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] s);
        for (int i = 0; i < 4; i++) exp_q.push_back(s[8*i +: 8]);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_time"}, 32'(n < budget), 32'd1);
        repeat (8) @(negedge clk);
        check({name, "_all_bytes_seen"}, exp_q.size(), 0);
        check({name, "_line_idle"}, uart_tx, 1'b1);
    endtask

    // UART monitor: samples mid-bit on negedges; a byte overlapping reset is discarded.
    initial begin : monitor
        logic [7:0] b;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_tx === 1'b0) begin
                starts.push_back(cyc);
                ab = 1'b0;
                b  = '0;
                repeat (CPB / 2) @(negedge clk);
                if (!rst) ab = 1'b1;
                else check("rx_start_bit", uart_tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (!rst) ab = 1'b1;
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (!rst) ab = 1'b1;
                if (!ab) begin
                    check("rx_stop_bit", uart_tx, 1'b1);
                    rx_bytes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got byte %0h, expected none", b);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int t0;
        int rx0;
        int n;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_fifo_full", bus.fifo_full, 1'b0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_overflow", bus.overflow, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single sample, frame length and byte order
        starts.delete();
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'h1234_5678;
        push_exp(32'h1234_5678);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        t0 = cyc;
        check("t1_count", bus.fifo_count, 1);
        check("t1_busy", bus.busy, 1'b1);
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t1_busy_fall_cycles", cyc - t0, 161);
        repeat (8) @(negedge clk);
        check("t1_all_bytes_seen", exp_q.size(), 0);
        check("t1_byte_count", starts.size(), 4);
        check("t1_byte_span", (starts.size() >= 4) ? starts[3] - starts[0] : -1, 3 * 10 * CPB);

        // 2: three back-to-back samples, no idle bits between bytes
        starts.delete();
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'hA5A5_A5A5;
        push_exp(32'hA5A5_A5A5);
        @(negedge clk);
        check("t2_count_a", bus.fifo_count, 1);
        bus.sample_data = 32'h0000_0001;
        push_exp(32'h0000_0001);
        @(negedge clk);
        check("t2_count_b", bus.fifo_count, 1);
        bus.sample_data = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFF);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check("t2_count_c", bus.fifo_count, 2);
        wait_idle(700, "t2");
        check("t2_byte_count", starts.size(), 12);
        check("t2_byte_span", (starts.size() >= 12) ? starts[11] - starts[0] : -1, 11 * 10 * CPB);

        // 3: overflow on the sixth consecutive push
        rx0 = rx_bytes;
        for (int i = 0; i < 6; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_data  = 32'h1020_3040 + 32'(i);
            if (i < 5) push_exp(32'h1020_3040 + 32'(i));
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        check("t3_overflow", bus.overflow, 1'b1);
        check("t3_fifo_full", bus.fifo_full, 1'b1);
        check("t3_count", bus.fifo_count, 4);
        wait_idle(1000, "t3");
        check("t3_bytes_sent", rx_bytes - rx0, 20);
        check("t3_overflow_sticky", bus.overflow, 1'b1);
        rst = 1'b0;
        #1;
        check("t3_overflow_cleared", bus.overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 4: reset during bit 3 of byte 2 with two samples queued
        rx0 = rx_bytes;
        exp_q.push_back(8'h0D);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'hCAFE_F00D;
        @(negedge clk);
        t0 = cyc;
        bus.sample_data = 32'h1111_1111;
        @(negedge clk);
        bus.sample_data = 32'h2222_2222;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check("t4_count_queued", bus.fifo_count, 2);
        while (cyc < t0 + 59) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_rst_uart_tx", uart_tx, 1'b1);
        check("t4_rst_busy", bus.busy, 1'b0);
        check("t4_rst_count", bus.fifo_count, 0);
        starts.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("t4_line_idle", uart_tx, 1'b1);
        check("t4_busy_after", bus.busy, 1'b0);
        check("t4_no_new_frames", starts.size(), 0);
        check("t4_bytes_before_rst", rx_bytes - rx0, 1);
        check("t4_exp_drained", exp_q.size(), 0);

        // 5: level held three cycles pushes three copies
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            push_exp(32'h0000_BEEF);
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        check("t5_count", bus.fifo_count, 2);
        wait_idle(700, "t5");

        // 6: push into a full FIFO on the same edge as the FSM pops
        for (int i = 0; i < 5; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_data  = 32'h600D_0000 + 32'(i);
            push_exp(32'h600D_0000 + 32'(i));
            @(negedge clk);
            if (i == 0) t0 = cyc;
        end
        bus.sample_valid = 1'b0;
        check("t6_full", bus.fifo_full, 1'b1);
        check("t6_count_full", bus.fifo_count, 4);
        while (cyc < t0 + 160) @(negedge clk);
        check("t6_count_before", bus.fifo_count, 4);
        bus.sample_valid = 1'b1;
        bus.sample_data  = 32'h5A5A_0006;
        push_exp(32'h5A5A_0006);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        check("t6_count_after", bus.fifo_count, 4);
        check("t6_no_overflow", bus.overflow, 1'b0);
        wait_idle(1200, "t6");
        check("t6_overflow_final", bus.overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
